// File: rtl/fft_pkg.sv
// Shared constants, complex-bin type and helpers for the 16-point FFT datapath.
package fft_pkg;

  localparam int FFT_N     = 16;
  localparam int FFT_LOG2N = 4;
  localparam int CPLX_W    = 64;
  localparam int PART_W    = 32;

  typedef struct packed {
    logic signed [PART_W-1:0] re;
    logic signed [PART_W-1:0] im;
  } cplx_t;

  typedef enum logic {
    BANK_EMPTY = 1'b0,
    BANK_FULL  = 1'b1
  } bank_state_t;

  function automatic logic [FFT_LOG2N-1:0] bitrev4(input logic [FFT_LOG2N-1:0] a);
    bitrev4 = {a[0], a[1], a[2], a[3]};
  endfunction

endpackage

// File: rtl/fft_bitrev_serializer_if.sv
// Frame-in / bin-out handshake bundle of the bit-reversal serializer.
interface fft_bitrev_serializer_if;
  import fft_pkg::*;

  logic                      in_valid;
  logic                      in_ready;
  logic [FFT_N*CPLX_W-1:0]   in_bins;
  logic                      out_valid;
  logic                      out_ready;
  logic [CPLX_W-1:0]         out_data;
  logic [FFT_LOG2N-1:0]      out_idx;
  logic                      out_last;

  modport master (
    output in_valid, in_bins, out_ready,
    input  in_ready, out_valid, out_data, out_idx, out_last
  );

  modport slave (
    input  in_valid, in_bins, out_ready,
    output in_ready, out_valid, out_data, out_idx, out_last
  );

endinterface

// File: rtl/fft_frame_bank.sv
// One 16-slot frame buffer: parallel capture of a whole frame, single-slot read mux.
//   state      | meaning
//   BANK_EMPTY | free, may accept a frame
//   BANK_FULL  | holds a frame still being drained
module fft_frame_bank
  import fft_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic                     rel,
  input  logic [FFT_N*CPLX_W-1:0]  wr_bins,
  input  logic [FFT_LOG2N-1:0]     rd_addr,
  output logic                     full,
  output cplx_t                    rd_data
);

  bank_state_t state_q, state_d;
  cplx_t       mem [FFT_N];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= BANK_EMPTY;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      BANK_EMPTY: if (wr_en) state_d = BANK_FULL;
      BANK_FULL:  if (rel)   state_d = BANK_EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int j = 0; j < FFT_N; j++) mem[j] <= '0;
    end else if (wr_en) begin
      for (int j = 0; j < FFT_N; j++) mem[j] <= cplx_t'(wr_bins[j*CPLX_W +: CPLX_W]);
    end
  end

  assign full    = (state_q == BANK_FULL);
  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/fft_bitrev_serializer.sv
// Ping-pong capture of bit-reversed FFT frames, streamed out one bin per beat in natural order.
module fft_bitrev_serializer
  import fft_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst_n,
  fft_bitrev_serializer_if.slave   bus
);

  logic                  wr_sel;
  logic                  rd_sel;
  logic [FFT_LOG2N-1:0]  cnt;
  logic [1:0]            full;
  logic [1:0]            wr_en;
  logic [1:0]            rel;
  cplx_t                 rd_data [2];
  logic                  accept;
  logic                  beat;
  logic                  last_beat;

  // in_ready depends only on flop state, never on in_valid/out_ready.
  assign bus.in_ready  = !full[wr_sel];
  assign accept        = bus.in_valid && bus.in_ready;
  assign bus.out_valid = full[rd_sel];
  assign beat          = bus.out_valid && bus.out_ready;
  assign last_beat     = beat && (cnt == FFT_LOG2N'(FFT_N-1));

  for (genvar b = 0; b < 2; b++) begin : g_bank
    assign wr_en[b] = accept    && (wr_sel == 1'(b));
    assign rel[b]   = last_beat && (rd_sel == 1'(b));

    fft_frame_bank u_bank (
      .clk     (clk),
      .rst_n   (rst_n),
      .wr_en   (wr_en[b]),
      .rel     (rel[b]),
      .wr_bins (bus.in_bins),
      .rd_addr (bitrev4(cnt)),
      .full    (full[b]),
      .rd_data (rd_data[b])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_sel <= 1'b0;
      rd_sel <= 1'b0;
      cnt    <= '0;
    end else begin
      if (accept) wr_sel <= !wr_sel;
      if (last_beat) begin
        cnt    <= '0;
        rd_sel <= !rd_sel;
      end else if (beat) begin
        cnt    <= cnt + 1'b1;
      end
    end
  end

  assign bus.out_data = rd_data[rd_sel];
  assign bus.out_idx  = cnt;
  assign bus.out_last = bus.out_valid && (cnt == FFT_LOG2N'(FFT_N-1));

endmodule

// File: tb/tb_fft_bitrev_serializer.sv
// Randomized self-checking bench: frame-queue reference model checked every cycle, plus literal pins.
module tb_fft_bitrev_serializer;

  logic clk;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;

  fft_bitrev_serializer_if bus();

  fft_bitrev_serializer dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // model: queue of frames in natural order, plus read position in the head frame
  logic [1023:0] mq [$];
  int            pos = 0;
  logic [67:0]   beat_log [$];
  bit            rand_mode = 0;

  function automatic int tb_rev(input int j);
    return ((j & 1) << 3) | ((j & 2) << 1) | ((j & 4) >> 1) | ((j & 8) >> 3);
  endfunction

  function automatic logic [1023:0] to_nat(input logic [1023:0] slots);
    logic [1023:0] n;
    n = '0;
    for (int j = 0; j < 16; j++) n[tb_rev(j)*64 +: 64] = slots[j*64 +: 64];
    return n;
  endfunction

  function automatic logic [63:0] nat_bin(input logic [1023:0] n, input int k);
    return n[k*64 +: 64];
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // per-cycle compare against the model, then advance the model for the coming edge
  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
      chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
      chk("rst_out_last", 64'(bus.out_last), 64'd0);
      chk("rst_out_idx", 64'(bus.out_idx), 64'd0);
      chk("rst_out_data", bus.out_data, 64'd0);
      mq.delete();
      pos = 0;
    end else begin
      bit exp_rdy;
      bit exp_v;
      exp_rdy = (mq.size() < 2);
      exp_v   = (mq.size() > 0);
      chk("in_ready", 64'(bus.in_ready), 64'(exp_rdy));
      chk("out_valid", 64'(bus.out_valid), 64'(exp_v));
      if (exp_v) begin
        chk("out_idx", 64'(bus.out_idx), 64'(pos));
        chk("out_data", bus.out_data, nat_bin(mq[0], pos));
        chk("out_last", 64'(bus.out_last), 64'(pos == 15));
      end else begin
        chk("out_last_idle", 64'(bus.out_last), 64'd0);
      end
      if (bus.out_valid && bus.out_ready) beat_log.push_back({bus.out_idx, bus.out_data});
      if (exp_v && bus.out_ready) begin
        if (pos == 15) begin
          void'(mq.pop_front());
          pos = 0;
        end else begin
          pos++;
        end
      end
      if (bus.in_valid && exp_rdy) mq.push_back(to_nat(bus.in_bins));
    end
  end

  always @(posedge clk) begin
    if (rand_mode) begin
      #1 bus.out_ready = 1'($urandom_range(0, 1));
    end
  end

  task automatic offer(input logic [1023:0] f, input bit drop, output int edges);
    bit rdy;
    rdy = 0;
    edges = 0;
    bus.in_valid = 1'b1;
    bus.in_bins  = f;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      rdy = bus.in_ready;
      @(posedge clk);
      edges++;
      if (rdy) break;
    end
    chk("accept_within_budget", 64'(rdy), 64'd1);
    #1;
    if (drop) bus.in_valid = 1'b0;
  endtask

  task automatic drain_wait();
    bit idle;
    idle = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (!bus.out_valid) begin
        idle = 1;
        break;
      end
    end
    chk("drain_within_budget", 64'(idle), 64'd1);
    @(posedge clk);
    #1;
  endtask

  function automatic logic [1023:0] rand_frame();
    logic [1023:0] f;
    for (int w = 0; w < 32; w++) f[w*32 +: 32] = $urandom;
    return f;
  endfunction

  initial begin
    logic [1023:0] fa, fb, fc, fd, f1;
    logic [31:0]   re, im;
    int            e;
    bit            seen7;
    int            bp [4] = '{1, 0, 0, 1};

    rst_n = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_bins   = '0;
    bus.out_ready = 1'b0;
    #2;
    chk("init_in_ready", 64'(bus.in_ready), 64'd1);
    chk("init_out_valid", 64'(bus.out_valid), 64'd0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // single frame, bit-reversal pattern
    for (int j = 0; j < 16; j++) begin
      re = 32'(tb_rev(j)) << 16;
      im = -re;
      f1[j*64 +: 64] = {re, im};
    end
    bus.out_ready = 1'b1;
    beat_log.delete();
    offer(f1, 1'b1, e);
    chk("first_frame_edges", 64'(e), 64'd1);
    chk("valid_cycle_after_accept", 64'(bus.out_valid), 64'd1);
    chk("first_idx", 64'(bus.out_idx), 64'd0);
    drain_wait();
    chk("single_beats", 64'(beat_log.size()), 64'd16);
    for (int k = 0; k < 16 && k < beat_log.size(); k++) begin
      re = 32'(k) << 16;
      im = -re;
      chk("single_idx", 64'(beat_log[k][67:64]), 64'(k));
      chk("single_data", beat_log[k][63:0], {re, im});
    end

    // back-to-back A,B then C waits for A's last beat (simultaneous accept/release)
    fa = rand_frame(); fb = rand_frame(); fc = rand_frame();
    beat_log.delete();
    offer(fa, 1'b0, e);
    chk("a_edges", 64'(e), 64'd1);
    offer(fb, 1'b0, e);
    chk("b_edges", 64'(e), 64'd1);
    chk("both_full_in_ready", 64'(bus.in_ready), 64'd0);
    offer(fc, 1'b1, e);
    chk("c_wait_edges", 64'(e), 64'd16);
    drain_wait();
    chk("b2b_beats", 64'(beat_log.size()), 64'd48);
    if (beat_log.size() == 48) begin
      chk("b2b_a0", beat_log[0][63:0], nat_bin(to_nat(fa), 0));
      chk("b2b_b0", beat_log[16][63:0], nat_bin(to_nat(fb), 0));
      chk("b2b_c15", beat_log[47][63:0], nat_bin(to_nat(fc), 15));
    end

    // backpressure 1,0,0,1
    fa = rand_frame();
    beat_log.delete();
    offer(fa, 1'b1, e);
    for (int i = 0; i < 80; i++) begin
      bus.out_ready = 1'(bp[i % 4]);
      @(posedge clk);
      #1;
    end
    bus.out_ready = 1'b1;
    drain_wait();
    chk("bp_beats", 64'(beat_log.size()), 64'd16);
    for (int k = 0; k < 16 && k < beat_log.size(); k++)
      chk("bp_idx", 64'(beat_log[k][67:64]), 64'(k));

    // reset mid-drain at beat 7
    fd = rand_frame();
    offer(rand_frame(), 1'b1, e);
    seen7 = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bus.out_valid && bus.out_idx == 4'd7) begin
        seen7 = 1;
        break;
      end
    end
    chk("reached_beat7", 64'(seen7), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("async_rst_in_ready", 64'(bus.in_ready), 64'd1);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    beat_log.delete();
    offer(fd, 1'b1, e);
    drain_wait();
    chk("post_rst_beats", 64'(beat_log.size()), 64'd16);
    if (beat_log.size() > 0) begin
      chk("post_rst_idx0", 64'(beat_log[0][67:64]), 64'd0);
      chk("post_rst_data0", beat_log[0][63:0], nat_bin(to_nat(fd), 0));
    end

    // randomized traffic with random backpressure
    rand_mode = 1;
    for (int n = 0; n < 30; n++) begin
      offer(rand_frame(), 1'($urandom_range(0, 1)), e);
      if ($urandom_range(0, 2) == 0) begin
        bus.in_valid = 1'b0;
        repeat ($urandom_range(1, 20)) @(posedge clk);
        #1;
      end
    end
    bus.in_valid = 1'b0;
    rand_mode = 0;
    @(posedge clk);
    #2 bus.out_ready = 1'b1;
    drain_wait();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fft_bitrev_serializer.md
# fft_bitrev_serializer

- Output-side companion to the 16-point FFT datapath (`fft_stage1` onward). The FFT stages hand off 16 complex bins in one cycle, in bit-reversed order.
- This block captures each 16-bin frame into a two-bank ping-pong buffer.
- It then streams the bins out one per beat, in natural order (X[0]..X[15]), under valid/ready flow control.
- The FFT pipeline can deliver the next frame while the previous one is still draining.

## Interface
Parameters:
- N, 16: points per frame; fixed at 16 for this datapath.
- CPLX_W, 64: packed complex width, {real[63:32], imag[31:0]}, each half signed Q16.16.

Ports (one clock; reset is asynchronous and active-low):
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  frame present on in_bins.
- in_ready  output  1  a bank is free; frame is accepted when in_valid && in_ready.
- in_bins  input  N*CPLX_W  slot j at [64j+63:64j]; slot j holds bin bitrev4(j).
- out_valid  output  1  out_data holds a valid bin.
- out_ready  input  1  downstream accepts the beat.
- out_data  output  CPLX_W  complex bin X[out_idx], passed through unmodified.
- out_idx  output  4  natural-order bin index.
- out_last  output  1  high on the beat with out_idx==15 (qualified by out_valid).

## Operation
- Storage:
  - Two banks, each holding 16 x CPLX_W plus a `full` flag.
  - wr_sel: bank the next accepted frame goes to.
  - rd_sel: bank being drained.
  - cnt[3:0]: read beat counter.
- Accept: on in_valid && in_ready, latch all 16 slots into bank[wr_sel], set full[wr_sel], toggle wr_sel.
- in_ready = !full[wr_sel], driven from registers only. There is no combinational path from out_ready or in_valid to in_ready.
- Drain:
  - out_valid = full[rd_sel].
  - out_data = bank[rd_sel][bitrev4(cnt)].
  - out_idx = cnt.
  - out_last = out_valid && (cnt==15).
- On out_valid && out_ready:
  - If cnt<15: cnt increments.
  - If cnt==15: cnt returns to 0, full[rd_sel] clears, rd_sel toggles.
- Data stays bit-exact: no scaling, rounding or sign handling. The bit-reversal is purely a read-address permutation.
- States per bank: EMPTY → (accept) FULL → (last beat handshaken) EMPTY. The overall block state is the pair (full[0], full[1]).
- in_valid while !in_ready: no capture. The sender must hold in_bins stable until accepted.
- out_ready low: out_data, out_idx and out_last stay stable. cnt holds.

## Timing
- Reset values:
  - out_valid 0, out_last 0, out_idx 0, out_data 0.
  - in_ready 1.
  - full 0/0, wr_sel 0, rd_sel 0, cnt 0, all bank words 0.
- Latency: a frame accepted at edge t gives out_valid=1 for X[0] in the cycle after t, provided the other bank is empty.
- Throughput:
  - One bin per cycle with out_ready held high: 16 cycles per frame.
  - A continuous stream sustains one frame per 16 cycles.
- Simultaneous accept into one bank and last-beat release of the other in the same edge is legal, and both take effect.
- Both banks full with the last beat draining: in_ready=0 that cycle, and 1 the next cycle.
- Reset mid-frame: the partial drain is discarded and all state returns to reset values. There is no resume.
- cnt wraps 15→0 only on a handshaken beat. It never advances while out_valid=0.

## Structure
- Shared package `fft_pkg`:
  - constants FFT_N=16, FFT_LOG2N=4, CPLX_W=64, PART_W=32.
  - function bitrev4.
  - typedef cplx_t (packed real/imag).
- Sub-module `fft_frame_bank`:
  - one 16-entry register bank with a full flag, a parallel write port and a 4-bit-addressed read mux.
  - instantiated twice.
- Top level holds wr_sel, rd_sel, cnt and the handshake logic.

## Test plan
- Single frame, bit-reversal:
  - Stimulus: slot j = {32'(bitrev4(j))<<16, 32'(-bitrev4(j))<<16}, out_ready=1.
  - Response: 16 beats with out_idx 0..15, real = idx<<16, imag = -(idx<<16); out_last only on idx 15; out_valid first asserted the cycle after accept.
- Back-to-back frames:
  - Stimulus: frames A and B offered on consecutive cycles.
  - Response: both accepted (in_ready 1,1). A third frame C waits with in_ready=0 until A's last beat. Output stream is A0..A15, B0..B15 with no bubble.
- Backpressure:
  - Stimulus: out_ready toggled 1,0,0,1 during frame A.
  - Response: out_idx/out_data frozen while out_ready=0. No bin dropped or duplicated, verified against a reference model.
- Simultaneous accept/release:
  - Stimulus: both banks full; in_valid held.
  - Response: new frame accepted the cycle after the last beat of the first frame; it drains after the second frame.
- Reset mid-drain:
  - Stimulus: assert rst_n=0 at beat 7, release, send frame D.
  - Response: out_valid drops immediately (async) and in_ready=1 during reset; after release, D drains from idx 0 and contains no stale data.
